// File: rtl/ex_hilo_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers for the execute stage.
// MULT*/DIV* take WIDTH+1 edges from Start to Done; MTHI/MTLO write HI/LO in one edge.
module ex_hilo_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;

  logic               w_signed;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_dz_hi;
  logic               w_div_zero;
  logic               w_last;

  // Operand magnitudes: signed ops work on absolute values, signs re-applied at FIX.
  assign w_signed = (Op == 3'd0) || (Op == 3'd2);
  assign w_neg1   = w_signed && Rdata1[WIDTH-1];
  assign w_neg2   = w_signed && Rdata2[WIDTH-1];
  assign w_abs1   = w_neg1 ? -Rdata1 : Rdata1;
  assign w_abs2   = w_neg2 ? -Rdata2 : Rdata2;

  // Shift-add: {acc_hi,acc_lo} starts as {0,multiplier}, multiplicand added into the top.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

  // Restoring division: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  assign w_div_sh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ok   = ~w_div_diff[WIDTH];

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem      = r_neg_r ? -r_acc_hi : r_acc_hi;
  // Divide by zero returns the dividend as latched; its sign is rebuilt from the magnitude.
  assign w_dz_hi    = r_neg_r ? -r_a : r_a;
  assign w_div_zero = (r_b == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (!Op[2]) begin
              r_a      <= w_abs1;
              r_b      <= w_abs2;
              r_is_div <= Op[1];
              r_neg_q  <= w_neg1 ^ w_neg2;
              r_neg_r  <= w_neg1;
              r_cnt    <= '0;
              r_acc_hi <= '0;
              r_acc_lo <= Op[1] ? w_abs1 : w_abs2;
              r_busy   <= 1'b1;
              r_state  <= S_RUN;
            end else if (Op == 3'd4) begin
              r_hi <= Rdata1;
            end else if (Op == 3'd5) begin
              r_lo <= Rdata1;
            end
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_acc_hi <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ok};
          end else begin
            r_acc_hi <= w_mul_sum[WIDTH:1];
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else if (w_div_zero) begin
            r_hi <= w_dz_hi;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Self-checking bench for ex_hilo_muldiv: directed cases plus randomized operations
// on a 32-bit and an 8-bit instance, checked against an arithmetic reference model.
module tb_ex_hilo_muldiv;

  logic        clk;
  logic        rst;
  logic        st32, st8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, busy8, done8;

  int n_vec;
  int n_err;

  ex_hilo_muldiv #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .CLK(clk), .RST(rst), .Start(st32), .Op(op32), .Rdata1(a32), .Rdata2(b32),
    .Busy(busy32), .Done(done32), .HI(hi32), .LO(lo32)
  );

  ex_hilo_muldiv #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .CLK(clk), .RST(rst), .Start(st8), .Op(op8), .Rdata1(a8), .Rdata2(b8),
    .Busy(busy8), .Done(done8), .HI(hi8), .LO(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      st32 = st; op32 = op; a32 = a; b32 = b;
    end else begin
      st8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic logic [31:0] hi_of(input int w);
    return (w == 32) ? hi32 : {24'd0, hi8};
  endfunction
  function automatic logic [31:0] lo_of(input int w);
    return (w == 32) ? lo32 : {24'd0, lo8};
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 32) ? done32 : done8;
  endfunction

  // Reference: plain integer arithmetic on w-bit values, result packed as {HI,LO}.
  function automatic logic [63:0] ref_fn(input int w, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    longint unsigned m, ua, ub, p, hi, lo, one;
    longint sa, sb, t;
    one = 64'd1;
    m   = (one << w) - one;
    ua  = {32'd0, a} & m;
    ub  = {32'd0, b} & m;
    sa  = ua;
    sb  = ub;
    if (ua[w-1]) sa = sa - longint'(one << w);
    if (ub[w-1]) sb = sb - longint'(one << w);
    hi = 0;
    lo = 0;
    case (op)
      3'd0: begin t = sa * sb; p = t; hi = (p >> w) & m; lo = p & m; end
      3'd1: begin p = ua * ub; hi = (p >> w) & m; lo = p & m; end
      3'd2: begin
        if (sb == 0) begin lo = m; hi = ua; end
        else begin t = sa / sb; lo = t; lo = lo & m; t = sa % sb; hi = t; hi = hi & m; end
      end
      default: begin
        if (ub == 0) begin lo = m; hi = ua; end
        else begin lo = ua / ub; hi = ua % ub; end
      end
    endcase
    return {hi[31:0], lo[31:0]};
  endfunction

  function automatic logic [31:0] pick(input int w);
    int unsigned r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 32'd0;
      1: return (w == 32) ? 32'h8000_0000 : 32'h80;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Start an operation, optionally pulse a second Start at edge k+intr, check result.
  task automatic run_op(input int w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int intr,
                        input string tag);
    int n;
    bit both, moved;
    logic [31:0] old_hi, old_lo;
    old_hi = hi_of(w);
    old_lo = lo_of(w);
    drive(w, 1'b1, op, a, b);
    step();
    chk({tag, "_busy"}, {63'd0, busy_of(w)}, 64'd1);
    n = 0; both = 0; moved = 0;
    while (!done_of(w) && n < 200) begin
      if (hi_of(w) !== old_hi || lo_of(w) !== old_lo) moved = 1;
      if (intr != 0 && n == intr - 1) drive(w, 1'b1, 3'd1, 32'd5, 32'd5);
      else drive(w, 1'b0, 3'd6, $urandom, $urandom);
      step();
      n++;
      if (busy_of(w) && done_of(w)) both = 1;
    end
    drive(w, 1'b0, 3'd6, 32'd0, 32'd0);
    chk({tag, "_lat"}, 64'(n), 64'(w + 1));
    chk({tag, "_hilo"}, {hi_of(w), lo_of(w)}, exp);
    chk({tag, "_hold_bd"}, {62'd0, moved, both | busy_of(w)}, 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drive(32, 1'b0, 3'd6, 32'd0, 32'd0);
    drive(8, 1'b0, 3'd6, 32'd0, 32'd0);
    step(); step();
    rst = 1'b0;
    chk("reset32", {busy32, done32, hi32, lo32}, 66'd0);
    chk("reset8", {48'd0, busy8, done8, hi8, lo8}, 64'd0);

    // Directed 32-bit cases
    run_op(32, 3'd1, 32'd7, 32'd6, {32'd0, 32'h2A}, 0, "multu_7x6");
    run_op(32, 3'd0, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 0, "mult_m1x2");
    run_op(32, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h1}, 0, "multu_max");
    run_op(32, 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, "div_m7_2");
    run_op(32, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0, "div_ovf");
    run_op(32, 3'd3, 32'd100, 32'd0, {32'h64, 32'hFFFF_FFFF}, 0, "divu_by0");
    run_op(32, 3'd2, 32'hFFFF_FF9C, 32'd0, {32'hFFFF_FF9C, 32'hFFFF_FFFF}, 0, "div_neg_by0");

    // MTHI then MTLO on consecutive idle cycles
    drive(32, 1'b1, 3'd4, 32'h1234, 32'd0);
    step();
    chk("mthi", {busy32, done32, hi32}, {2'b00, 32'h1234});
    drive(32, 1'b1, 3'd5, 32'h5678, 32'd0);
    step();
    chk("mtlo", {busy32, done32, hi32, lo32}, {2'b00, 32'h1234, 32'h5678});
    drive(32, 1'b1, 3'd6, 32'hDEAD, 32'hBEEF);
    step();
    drive(32, 1'b1, 3'd7, 32'hDEAD, 32'hBEEF);
    step();
    chk("noop67", {busy32, done32, hi32, lo32}, {2'b00, 32'h1234, 32'h5678});
    drive(32, 1'b0, 3'd6, 32'd0, 32'd0);

    // Start while busy ignored, then back-to-back start in the Done cycle
    run_op(32, 3'd3, 32'd9, 32'd3, {32'd0, 32'd3}, 5, "divu_9_3_ign");
    run_op(32, 3'd0, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 0, "b2b_mult");

    // Reset in the middle of a MULT
    drive(32, 1'b1, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    drive(32, 1'b0, 3'd6, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid", {busy32, done32, hi32, lo32}, 66'd0);
    begin
      bit saw;
      saw = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (done32 || busy32) saw = 1;
      end
      chk("rst_no_done", {63'd0, saw}, 64'd0);
    end

    // Directed 8-bit cases
    run_op(8, 3'd1, 32'd7, 32'd6, {32'd0, 32'h2A}, 0, "w8_multu_7x6");
    run_op(8, 3'd0, 32'hFF, 32'd2, {32'hFF, 32'hFE}, 0, "w8_mult_m1x2");
    run_op(8, 3'd1, 32'hFF, 32'hFF, {32'hFE, 32'h01}, 0, "w8_multu_max");
    run_op(8, 3'd2, 32'hF9, 32'd2, {32'hFF, 32'hFD}, 0, "w8_div_m7_2");
    run_op(8, 3'd2, 32'h80, 32'hFF, {32'd0, 32'h80}, 0, "w8_div_ovf");
    run_op(8, 3'd3, 32'd100, 32'd0, {32'h64, 32'hFF}, 0, "w8_divu_by0");
    run_op(8, 3'd3, 32'd9, 32'd3, {32'd0, 32'd3}, 5, "w8_divu_ign");

    // Randomized operations on both widths
    for (int k = 0; k < 2; k++) begin
      int w;
      w = (k == 0) ? 32 : 8;
      for (int i = 0; i < 30; i++) begin
        logic [2:0]  op;
        logic [31:0] a, b;
        op = 3'($urandom_range(0, 3));
        a  = pick(w);
        b  = pick(w);
        run_op(w, op, a, b, ref_fn(w, op, a, b), 0, (w == 32) ? "rnd32" : "rnd8");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
